// File: rtl/pwm_ctrl_pkg.sv
// Shared types for pwm_ramp_ctrl: channel states, the command word and the clamped ramp stepper.
// Build option PWM_RAMP_BYPASS_EN adds the immediate-load flag to the command word.
package pwm_ctrl_pkg;

    localparam int CMD_CH_W   = 8;
    localparam int CMD_DUTY_W = 16;

    typedef enum logic [1:0] {OFF, RAMP, HOLD, STOP} chan_state_t;

    typedef struct packed {
        logic [CMD_CH_W-1:0]   ch;
        logic [CMD_DUTY_W-1:0] duty;
        logic                  en;
`ifdef PWM_RAMP_BYPASS_EN
        logic                  imm;
`endif
    } cmd_t;

    // Differences are taken before stepping, so the result never overshoots tgt or wraps.
    function automatic int unsigned clampStep(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step);
        if (tgt > cur) begin
            clampStep = (tgt - cur > step) ? cur + step : tgt;
        end else begin
            clampStep = (cur - tgt > step) ? cur - step : tgt;
        end
    endfunction

endpackage

// File: rtl/pwm_ramp_chan.sv
// One pwm_ramp_ctrl channel: OFF/RAMP/HOLD/STOP FSM with target and current duty registers.
// With PWM_RAMP_BYPASS_EN a command may request an immediate load at the next period tick.
module pwm_ramp_chan
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stepEvt_i,
`ifdef PWM_RAMP_BYPASS_EN
    input  logic             periodTick_i,
`endif
    input  logic             cmdHit_i,
    input  cmd_t             cmd_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             enable_o,
    output logic             settled_o,
    output logic             settlePulse_o
);
    chan_state_t      state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d, tgt_q, tgt_d;
    logic [WIDTH-1:0] tgtEff, stepped, cmdDuty;
    logic             settlePulse_q, settlePulse_d;
    logic             unusedCmdBits;
`ifdef PWM_RAMP_BYPASS_EN
    logic             imm_q, imm_d;
`endif

    assign unusedCmdBits = ^{cmd_i.ch, cmd_i.duty};
    assign cmdDuty       = WIDTH'(cmd_i.duty);
    assign tgtEff        = (state_q == STOP) ? '0 : tgt_q;
    assign stepped       = WIDTH'(clampStep(32'(cur_q), 32'(tgtEff), 32'(STEP)));

    // Step first with the old target, then let a same-edge command override the state.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
`ifdef PWM_RAMP_BYPASS_EN
        imm_d   = imm_q;
`endif
        if (stepEvt_i && (state_q == RAMP || state_q == STOP)) begin
            cur_d = stepped;
            if (stepped == tgtEff) begin
                state_d = (state_q == RAMP) ? HOLD : OFF;
            end
        end
`ifdef PWM_RAMP_BYPASS_EN
        if (imm_q && periodTick_i) begin
            cur_d   = tgt_q;
            state_d = (state_q == STOP) ? OFF : HOLD;
            imm_d   = 1'b0;
        end
`endif
        if (cmdHit_i) begin
            if (cmd_i.en) begin
                tgt_d   = cmdDuty;
                state_d = (cmdDuty == cur_d) ? HOLD : RAMP;
`ifdef PWM_RAMP_BYPASS_EN
                imm_d   = cmd_i.imm;
`endif
            end else if (state_q != OFF) begin
                tgt_d   = '0;
                state_d = STOP;
`ifdef PWM_RAMP_BYPASS_EN
                imm_d   = cmd_i.imm;
`endif
            end
        end
        settlePulse_d = (state_d == HOLD || state_d == OFF) &&
                        (state_q == RAMP || state_q == STOP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= OFF;
            cur_q         <= '0;
            tgt_q         <= '0;
            settlePulse_q <= 1'b0;
`ifdef PWM_RAMP_BYPASS_EN
            imm_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            tgt_q         <= tgt_d;
            settlePulse_q <= settlePulse_d;
`ifdef PWM_RAMP_BYPASS_EN
            imm_q         <= imm_d;
`endif
        end
    end

    assign duty_o        = cur_q;
    assign enable_o      = (state_q != OFF);
    assign settled_o     = (state_q == HOLD) || (state_q == OFF);
    assign settlePulse_o = settlePulse_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel duty ramp scheduler in front of NCH pwm blocks: divider, command decode, packing.
// Define PWM_RAMP_BYPASS_EN to add cmd_imm (load target at the next period tick, no ramp).
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int NCH      = 4,
    parameter int RAMP_DIV = 4,
    parameter int STEP     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   period_tick,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [$clog2(NCH)-1:0] cmd_ch,
    input  logic [WIDTH-1:0]       cmd_duty,
    input  logic                   cmd_en,
`ifdef PWM_RAMP_BYPASS_EN
    input  logic                   cmd_imm,
`endif
    output logic [NCH*WIDTH-1:0]   duty_out,
    output logic [NCH-1:0]         enable_out,
    output logic [NCH-1:0]         settled,
    output logic [NCH-1:0]         settle_pulse
);
    localparam int DIVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [DIVW-1:0] div_q, div_d;
    logic            stepEvt, cmdFire;
    logic [NCH-1:0]  cmdHit;
    cmd_t            cmd;

    assign cmd_ready = reset_n;
    assign cmdFire   = cmd_valid && cmd_ready;
    assign stepEvt   = period_tick && (div_q == DIVW'(RAMP_DIV - 1));

    always_comb begin
        cmd      = '0;
        cmd.ch   = CMD_CH_W'(cmd_ch);
        cmd.duty = CMD_DUTY_W'(cmd_duty);
        cmd.en   = cmd_en;
`ifdef PWM_RAMP_BYPASS_EN
        cmd.imm  = cmd_imm;
`endif
    end

    always_comb begin
        div_d = div_q;
        if (period_tick) begin
            div_d = (div_q == DIVW'(RAMP_DIV - 1)) ? '0 : div_q + DIVW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Channel numbers with no matching instance simply hit nothing and are dropped.
    for (genvar k = 0; k < NCH; k++) begin : gChan
        assign cmdHit[k] = cmdFire && (cmd.ch == CMD_CH_W'(k));

        pwm_ramp_chan #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) uChan (
            .clk           (clk),
            .reset_n       (reset_n),
            .stepEvt_i     (stepEvt),
`ifdef PWM_RAMP_BYPASS_EN
            .periodTick_i  (period_tick),
`endif
            .cmdHit_i      (cmdHit[k]),
            .cmd_i         (cmd),
            .duty_o        (duty_out[k*WIDTH +: WIDTH]),
            .enable_o      (enable_out[k]),
            .settled_o     (settled[k]),
            .settlePulse_o (settle_pulse[k])
        );
    end

endmodule
